// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the RAM port arbiter: default widths, requester
// encoding and FSM state encoding.
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;
    localparam int RD_LAT_DEF = 1;

    // Read-wait counter width; large enough for the maximum read latency of 3.
    localparam int CNT_W = 2;

    // Requester identity, also used as the round-robin "last winner" value.
    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_EXT = 1'b1
    } req_t;

    // IDLE may issue an access; RD_WAIT holds off all issues until read data returns.
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RD_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/mem_port_arbiter_dff.sv
// Resettable flip-flop: asynchronous active-low clear to a parameterised value.
module mem_port_arbiter_dff #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Plain register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin picker. Index 0 is the CPU, index 1 the loader port.
// With both eligible, the one that did not win last time is chosen.
module rr_pick2 (
    input  logic [1:0] elig,
    input  logic       last,
    output logic       winner,
    output logic       valid
);

    // A single eligible requester wins outright; a tie goes to the other side of last.
    always_comb begin
        valid  = |elig;
        winner = (elig == 2'b11) ? ~last : elig[1];
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port RAM between the CPU memory path and an external
// loader/debug port. Accesses issue combinationally in IDLE; a read parks the
// FSM in RD_WAIT until its data has been captured for the requester that
// issued it, so read data can never be delivered to the wrong side.
//
// Handshake: a requester raises req with we/addr/wdata and holds all of them
// stable until it sees gnt high for one cycle; the access is issued to the RAM
// in that same cycle. Read data is then returned as a one-cycle rvalid pulse
// with rdata, RD_LAT+1 cycles after gnt. Dropping req before gnt cancels it.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = RD_LAT_DEF   // legal range 1..3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,
    input  logic              ext_lock,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              dbg_state
);

    logic             state_raw;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             last_q;
    logic             last_d;
    logic             owner_q;
    logic             owner_d;

    logic             pick_winner;
    logic             pick_valid;
    logic             issue;
    logic             issue_we;
    logic             rd_done;

    // State, counter, round-robin history and read owner registers.
    mem_port_arbiter_dff #(.W(1), .RST_VAL(1'b0)) u_state_ff (
        .clk   (clk),
        .rst_n (reset),
        .d     (state_d),
        .q     (state_raw)
    );

    mem_port_arbiter_dff #(.W(CNT_W), .RST_VAL('0)) u_cnt_ff (
        .clk   (clk),
        .rst_n (reset),
        .d     (cnt_d),
        .q     (cnt_q)
    );

    // After reset the loader counts as the last winner, so a tie goes to the CPU first.
    mem_port_arbiter_dff #(.W(1), .RST_VAL(1'b1)) u_last_ff (
        .clk   (clk),
        .rst_n (reset),
        .d     (last_d),
        .q     (last_q)
    );

    mem_port_arbiter_dff #(.W(1), .RST_VAL(1'b0)) u_owner_ff (
        .clk   (clk),
        .rst_n (reset),
        .d     (owner_d),
        .q     (owner_q)
    );

    assign state_q   = state_t'(state_raw);
    assign busy      = (state_q == ST_RD_WAIT);
    assign dbg_state = state_raw;

    // The lock only masks the CPU; the loader is always eligible when requesting.
    rr_pick2 u_pick (
        .elig   ({ext_req, cpu_req & ~ext_lock}),
        .last   (last_q),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    assign issue    = (state_q == ST_IDLE) && pick_valid;
    assign issue_we = (pick_winner == REQ_EXT) ? ext_we : cpu_we;
    // Counter at 1 means mem_rdata is valid this cycle for the outstanding read.
    assign rd_done  = (state_q == ST_RD_WAIT) && (cnt_q == CNT_W'(1));

    // Next-state: reads park in RD_WAIT for RD_LAT cycles, writes stay in IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        owner_d = owner_q;
        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    last_d = pick_winner;
                    if (!issue_we) begin
                        state_d = ST_RD_WAIT;
                        cnt_d   = CNT_W'(RD_LAT);
                        owner_d = pick_winner;
                    end
                end
            end
            ST_RD_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (rd_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs: route the winner onto the RAM bus; bus fields are zero when nothing issues.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_gnt   = 1'b0;
        ext_gnt   = 1'b0;
        if (issue) begin
            mem_en = 1'b1;
            if (pick_winner == REQ_EXT) begin
                mem_we    = ext_we;
                mem_addr  = ext_addr;
                mem_wdata = ext_wdata;
                ext_gnt   = 1'b1;
            end else begin
                mem_we    = cpu_we;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                cpu_gnt   = 1'b1;
            end
        end
    end

    // Read return: capture into the owner's register only; the other side keeps its data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_rvalid <= 1'b0;
            ext_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            ext_rdata  <= '0;
        end else begin
            cpu_rvalid <= rd_done && (owner_q == REQ_CPU);
            ext_rvalid <= rd_done && (owner_q == REQ_EXT);
            if (rd_done && (owner_q == REQ_CPU)) begin
                cpu_rdata <= mem_rdata;
            end
            if (rd_done && (owner_q == REQ_EXT)) begin
                ext_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one instance at RD_LAT=1 for the main checks,
// a second at RD_LAT=3 for latency checks. Each has a small RAM model.
module tb_mem_port_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT (RD_LAT = 1) ----------------
    logic          cpu_req, cpu_we, ext_req, ext_we, ext_lock;
    logic [AW-1:0] cpu_addr, ext_addr, mem_addr;
    logic [DW-1:0] cpu_wdata, ext_wdata, mem_wdata, mem_rdata;
    logic [DW-1:0] cpu_rdata, ext_rdata;
    logic          cpu_gnt, cpu_rvalid, ext_gnt, ext_rvalid;
    logic          mem_en, mem_we, busy, dbg_state;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .ext_req    (ext_req),
        .ext_we     (ext_we),
        .ext_addr   (ext_addr),
        .ext_wdata  (ext_wdata),
        .ext_gnt    (ext_gnt),
        .ext_rvalid (ext_rvalid),
        .ext_rdata  (ext_rdata),
        .ext_lock   (ext_lock),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    logic [DW-1:0] ram1 [256];
    logic [DW-1:0] p1;
    always @(posedge clk) begin
        if (mem_en && mem_we) ram1[mem_addr] <= mem_wdata;
        p1 <= (mem_en && !mem_we) ? ram1[mem_addr] : '0;
    end
    assign mem_rdata = p1;

    // ---------------- DUT (RD_LAT = 3) ----------------
    logic          u3_ext_req, u3_ext_we;
    logic [AW-1:0] u3_ext_addr, u3_mem_addr;
    logic [DW-1:0] u3_ext_wdata, u3_mem_wdata, u3_mem_rdata;
    logic [DW-1:0] u3_cpu_rdata, u3_ext_rdata;
    logic          u3_cpu_gnt, u3_cpu_rvalid, u3_ext_gnt, u3_ext_rvalid;
    logic          u3_mem_en, u3_mem_we, u3_busy, u3_dbg_state;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut3 (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (1'b0),
        .cpu_we     (1'b0),
        .cpu_addr   ('0),
        .cpu_wdata  ('0),
        .cpu_gnt    (u3_cpu_gnt),
        .cpu_rvalid (u3_cpu_rvalid),
        .cpu_rdata  (u3_cpu_rdata),
        .ext_req    (u3_ext_req),
        .ext_we     (u3_ext_we),
        .ext_addr   (u3_ext_addr),
        .ext_wdata  (u3_ext_wdata),
        .ext_gnt    (u3_ext_gnt),
        .ext_rvalid (u3_ext_rvalid),
        .ext_rdata  (u3_ext_rdata),
        .ext_lock   (1'b0),
        .mem_en     (u3_mem_en),
        .mem_we     (u3_mem_we),
        .mem_addr   (u3_mem_addr),
        .mem_wdata  (u3_mem_wdata),
        .mem_rdata  (u3_mem_rdata),
        .busy       (u3_busy),
        .dbg_state  (u3_dbg_state)
    );

    logic [DW-1:0] ram3 [256];
    logic [DW-1:0] p3 [3];
    always @(posedge clk) begin
        if (u3_mem_en && u3_mem_we) ram3[u3_mem_addr] <= u3_mem_wdata;
        p3[0] <= (u3_mem_en && !u3_mem_we) ? ram3[u3_mem_addr] : '0;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign u3_mem_rdata = p3[2];

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [DW-1:0] shadow [256];
    logic [DW-1:0] cpu_exp_q [$];
    logic [DW-1:0] ext_exp_q [$];
    int cpu_rd_cyc = 0;
    int ext_rd_cyc = 0;

    // Returned data is compared against the queue; latency against the read's gnt cycle.
    always @(negedge clk) begin
        if (cpu_rvalid) begin
            if (cpu_exp_q.size() == 0) check("cpu_rvalid_unexpected", 1, 0);
            else begin
                check("cpu_rdata", cpu_rdata, cpu_exp_q.pop_front());
                check("cpu_rd_lat", cyc - cpu_rd_cyc, 2);
            end
        end
        if (ext_rvalid) begin
            if (ext_exp_q.size() == 0) check("ext_rvalid_unexpected", 1, 0);
            else begin
                check("ext_rdata", ext_rdata, ext_exp_q.pop_front());
                check("ext_rd_lat", cyc - ext_rd_cyc, 2);
            end
        end
        if (cpu_gnt && !mem_we) cpu_rd_cyc = cyc;
        if (ext_gnt && !mem_we) ext_rd_cyc = cyc;
    end

    // ---------------- driver tasks ----------------
    task automatic cpu_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        @(negedge clk);
        while (cpu_gnt !== 1'b1 && n < 40) begin n++; @(negedge clk); end
        check("cpu_gnt_wait", cpu_gnt, 1);
        if (cpu_gnt === 1'b1) begin
            if (we) shadow[a] = d;
            else cpu_exp_q.push_back(shadow[a]);
        end
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    endtask

    task automatic ext_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        ext_req = 1'b1; ext_we = we; ext_addr = a; ext_wdata = d;
        @(negedge clk);
        while (ext_gnt !== 1'b1 && n < 40) begin n++; @(negedge clk); end
        check("ext_gnt_wait", ext_gnt, 1);
        if (ext_gnt === 1'b1) begin
            if (we) shadow[a] = d;
            else ext_exp_q.push_back(shadow[a]);
        end
        @(posedge clk); #1;
        ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
    endtask

    task automatic drain();
        int n = 0;
        while ((cpu_exp_q.size() + ext_exp_q.size()) != 0 && n < 20) begin n++; @(negedge clk); end
        check("drain", cpu_exp_q.size() + ext_exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    int lat;
    int bcnt;

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram1[i] = '0; ram3[i] = '0; shadow[i] = '0;
        end
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        ext_req = 0; ext_we = 0; ext_addr = '0; ext_wdata = '0; ext_lock = 0;
        u3_ext_req = 0; u3_ext_we = 0; u3_ext_addr = '0; u3_ext_wdata = '0;
        reset = 1'b0;
        @(negedge clk);
        check("rst_outputs", {cpu_gnt, cpu_rvalid, cpu_rdata, ext_gnt, ext_rvalid, ext_rdata,
                              mem_en, mem_we, mem_addr, mem_wdata, busy}, 0);
        check("rst_state", dbg_state, 0);
        @(posedge clk); #1 reset = 1'b1;

        // 1: reset in the cycle after a read grant discards the read
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
        @(negedge clk);
        check("t1_gnt", cpu_gnt, 1);
        check("t1_mem_addr", mem_addr, 8'h10);
        @(posedge clk); #1;
        cpu_req = 0; cpu_addr = '0; reset = 1'b0;
        @(negedge clk);
        check("t1_outs_in_reset", {cpu_gnt, cpu_rvalid, cpu_rdata, ext_gnt, ext_rvalid, ext_rdata,
                                   mem_en, mem_we, mem_addr, mem_wdata, busy}, 0);
        @(posedge clk); #1 reset = 1'b1;
        repeat (4) @(negedge clk);
        check("t1_busy_after", busy, 0);
        check("t1_rvalid_after", cpu_rvalid, 0);
        @(posedge clk); #1;

        // 2: solo CPU write then read back
        cpu_access(1'b1, 8'h05, 16'hBEEF);
        cpu_access(1'b0, 8'h05, 16'h0000);
        drain();
        check("t2_ext_rdata_untouched", ext_rdata, 0);
        check("t2_cpu_rdata_hold", cpu_rdata, 16'hBEEF);

        // 3: contention from reset alternates C, E, C, E
        do_reset();
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h01; cpu_wdata = 16'h1111;
        ext_req = 1; ext_we = 1; ext_addr = 8'h02; ext_wdata = 16'h2222;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t3_cpu_gnt", cpu_gnt, (i % 2) == 0);
            check("t3_ext_gnt", ext_gnt, (i % 2) == 1);
            check("t3_mem_addr", mem_addr, ((i % 2) == 0) ? 8'h01 : 8'h02);
            @(posedge clk); #1;
        end
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        ext_req = 0; ext_we = 0; ext_addr = '0; ext_wdata = '0;
        shadow[8'h01] = 16'h1111;
        shadow[8'h02] = 16'h2222;
        ext_access(1'b0, 8'h01, 16'h0000);
        cpu_access(1'b0, 8'h02, 16'h0000);
        drain();

        // 4: lock blocks CPU grants until it drops
        ext_lock = 1; cpu_req = 1; cpu_we = 1; cpu_addr = 8'h30; cpu_wdata = 16'h3030;
        repeat (5) begin
            @(negedge clk);
            check("t4_locked_gnt", cpu_gnt, 0);
            check("t4_locked_mem_en", mem_en, 0);
            @(posedge clk); #1;
        end
        ext_lock = 0;
        @(negedge clk);
        check("t4_unlock_gnt", cpu_gnt, 1);
        if (cpu_gnt === 1'b1) shadow[8'h30] = 16'h3030;
        @(posedge clk); #1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;

        // 5: CPU stalled behind an EXT read, granted in the rvalid cycle
        ext_access(1'b1, 8'h20, 16'h1234);
        ext_req = 1; ext_we = 0; ext_addr = 8'h20;
        @(negedge clk);
        check("t5_ext_gnt", ext_gnt, 1);
        if (ext_gnt === 1'b1) ext_exp_q.push_back(shadow[8'h20]);
        @(posedge clk); #1;
        ext_req = 0; ext_addr = '0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h30;
        @(negedge clk);
        check("t5_busy", busy, 1);
        check("t5_dbg_state", dbg_state, 1);
        check("t5_cpu_stalled", cpu_gnt, 0);
        @(negedge clk);
        check("t5_ext_rvalid", ext_rvalid, 1);
        check("t5_cpu_gnt_same_cycle", cpu_gnt, 1);
        if (cpu_gnt === 1'b1) cpu_exp_q.push_back(shadow[8'h30]);
        @(posedge clk); #1;
        cpu_req = 0; cpu_addr = '0;
        drain();
        check("t5_ext_rdata_hold", ext_rdata, 16'h1234);

        // lock rising during an outstanding CPU read does not cancel it
        cpu_access(1'b0, 8'h05, 16'h0000);
        ext_lock = 1;
        drain();
        ext_lock = 0;

        // 6: RD_LAT = 3 instance
        u3_ext_req = 1; u3_ext_we = 1; u3_ext_addr = 8'h40; u3_ext_wdata = 16'hA5A5;
        @(negedge clk);
        check("t6_wr_gnt", u3_ext_gnt, 1);
        @(posedge clk); #1;
        u3_ext_we = 0; u3_ext_wdata = '0;
        @(negedge clk);
        check("t6_rd_gnt", u3_ext_gnt, 1);
        @(posedge clk); #1;
        u3_ext_req = 0; u3_ext_addr = '0;
        lat = 0; bcnt = 0;
        do begin
            @(negedge clk);
            lat++;
            if (u3_busy) bcnt++;
        end while (!u3_ext_rvalid && lat < 20);
        check("t6_gnt_to_rvalid", lat, 4);
        check("t6_busy_cycles", bcnt, 3);
        check("t6_rdata", u3_ext_rdata, 16'hA5A5);
        check("t6_cpu_rdata_untouched", u3_cpu_rdata, 0);
        @(negedge clk);
        check("t6_rvalid_pulse", u3_ext_rvalid, 0);

        check("final_queues", cpu_exp_q.size() + ext_exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port instruction/data RAM between two requesters:
  - the CPU, meaning the controller/datapath memory path that drives address, write enable and write data;
  - an external loader/debug port that fills or inspects RAM.
- Sits between both requesters and the RAM.
- Arbitrates round-robin, with an optional loader lock.
- Tracks outstanding reads so that each read's data is returned only to the requester that issued it.

Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 16, RAM data width.
- RD_LAT, 1, RAM read latency in cycles (mem_rdata is valid RD_LAT cycles after a read issue); legal range 1..3.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; held until cpu_gnt.
- cpu_we  in  1  1 = write, 0 = read; valid with cpu_req.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  one-cycle pulse: CPU access issued to RAM this cycle.
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid.
- cpu_rdata  out  DATA_W  CPU read data.
- ext_req, ext_we, ext_addr, ext_wdata, ext_gnt, ext_rvalid, ext_rdata: same roles and widths for the loader port.
- ext_lock  in  1  while 1, the CPU is never granted.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data.
- busy  out  1  a read is outstanding (state RD_WAIT).

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE, last_winner = EXT, read-wait counter = 0.
  - All outputs 0, including rdata buses.
  - A reset mid-read discards the read: no rvalid pulse follows.
- Registers vs. combinational outputs:
  - State, last_winner, counter, read owner and rdata outputs are registered.
  - gnt and mem_* are combinational from state, requests, ext_lock and last_winner (zero-latency issue).
- FSM states:
  - IDLE: may issue an access.
  - RD_WAIT: read outstanding; no issue allowed.
- Eligibility:
  - cpu_elig = cpu_req & ~ext_lock.
  - ext_elig = ext_req.
- Winner selection in IDLE:
  - Only one requester eligible: that requester wins.
  - Both eligible: the requester that is not last_winner wins.
  - Neither eligible: no issue, mem_en = 0.
- On issue:
  - mem_en = 1; mem_we/mem_addr/mem_wdata come from the winner; the winner's gnt = 1.
  - last_winner updates at the next edge.
- Writes:
  - Single cycle; the FSM stays in IDLE.
  - Back-to-back writes are allowed every cycle, alternating under contention.
- Reads:
  - The FSM moves to RD_WAIT with counter = RD_LAT and the read owner recorded.
  - Counter decrements each cycle.
  - When the counter reaches 1, mem_rdata is captured into the owner's rdata register. On the next cycle the owner's rvalid = 1 for one cycle and the FSM returns to IDLE.
  - A new issue is allowed in that same rvalid cycle.
  - Read-to-next-issue spacing is RD_LAT+1 cycles; gnt to rvalid is RD_LAT+1 cycles.
- Data holding:
  - A non-owner's rdata is never modified.
  - Each owner's rdata holds its last value until that owner's next read completes.
- Requests during RD_WAIT are stalled (no gnt). Requesters must hold req, we, addr and wdata stable until gnt.
- ext_lock rises while a CPU read is outstanding: that read completes normally; the lock only blocks new CPU grants.
- A request dropped before its grant is legal; nothing is issued for it.
- mem_we = 0 whenever mem_en = 0. mem_addr and mem_wdata are 0 when idle, for deterministic waveforms.

Decomposition:
- Shared package: ADDR_W/DATA_W defaults, requester encoding (CPU = 1'b0, EXT = 1'b1), FSM state encoding (IDLE, RD_WAIT).
- One natural sub-module: rr_pick2, a combinational 2-way round-robin picker with inputs elig[1:0] and last and outputs winner and valid.
- State and counter registers use the codebase flip-flop module, extended for the asynchronous active-low clear.

Test Plan:
1. Reset mid-read: CPU read addr 0x10, assert reset on the cycle after gnt -> no cpu_rvalid; all outputs 0; busy = 0.
2. Solo CPU write then read (RD_LAT = 1): write 0x05 <- 0xBEEF, then read 0x05 -> cpu_gnt pulses on both; cpu_rvalid 2 cycles after the read gnt with cpu_rdata = 0xBEEF; ext_rdata unchanged (0).
3. Contention from reset: both request a write in the same cycle -> CPU granted first (last_winner = EXT), EXT next cycle; with both requests held, writes to 0x01/0x02 alternate C, E, C, E.
4. Lock: ext_lock = 1 with cpu_req held 5 cycles and ext_req idle -> no cpu_gnt and mem_en = 0; lock drops -> cpu_gnt in the same cycle.
5. Read stall: EXT read 0x20 (RAM holds 0x1234) granted, CPU requests the next cycle -> cpu_gnt withheld while busy = 1; ext_rvalid with 0x1234, then cpu_gnt in that same cycle.
6. RD_LAT = 3 rebuild: EXT read -> ext_rvalid exactly 4 cycles after ext_gnt; busy high 3 cycles.
